// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin memory arbiter slice.
//   arbState_t  : 2-bit FSM encoding (IDLE, REQUEST, WAIT, DONE)
//   timerWidth  : width of the WAIT-cycle timer for a given timeout
// ---------------------------------------------------------------------------
package rr_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_REQUEST = 2'd1,
      ARB_WAIT    = 2'd2,
      ARB_DONE    = 2'd3
   } arbState_t;

   // The timer only ever counts up to timeout-1, so $clog2(timeout) bits are
   // enough; never let the width collapse to zero for tiny timeouts.
   function automatic int timerWidth(input int timeout);
      int w;
      w = $clog2(timeout);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
// Combinational round-robin picker: finds the first set request bit scanning
// from the pointer upwards, wrapping from NUM_PORTS-1 back to 0.
// Ports:
//   i_req    : request vector, one bit per port
//   i_ptr    : index that has highest priority this round (< NUM_PORTS)
//   o_any    : at least one request bit is set
//   o_winner : index of the chosen port (0 when o_any is low)
// ---------------------------------------------------------------------------
module arb_rr_pick
   import rr_arb_pkg::*;
#(
   parameter int  NUM_PORTS = 4,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [IDX_W-1:0]     i_ptr,
   output logic                 o_any,
   output logic [IDX_W-1:0]     o_winner
);

   logic [NUM_PORTS-1:0] w_reqRot;
   logic [IDX_W-1:0]     w_offset;

   // Adds two indices modulo NUM_PORTS; one extra bit holds the carry so the
   // wrap works for port counts that are not a power of two.
   function automatic logic [IDX_W-1:0] wrapAdd(input logic [IDX_W-1:0] a,
                                                input logic [IDX_W-1:0] b);
      logic [IDX_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (IDX_W+1)'(NUM_PORTS)) begin
         s = s - (IDX_W+1)'(NUM_PORTS);
      end
      return s[IDX_W-1:0];
   endfunction

   // Rotate the request vector so that bit 0 is the port at the pointer.
   always_comb begin
      w_reqRot = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_reqRot[i] = i_req[wrapAdd(i_ptr, IDX_W'(i))];
      end
   end

   // Priority-encode the rotated vector: lowest set bit is the offset from
   // the pointer to the winner.
   always_comb begin
      w_offset = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (w_reqRot[i]) begin
            w_offset = IDX_W'(i);
         end
      end
   end

   assign o_any    = |i_req;
   assign o_winner = wrapAdd(i_ptr, w_offset);

endmodule

// File: rtl/rr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mem_arbiter
// Work-conserving round-robin arbiter sharing one pulse-request / busy-wait
// memory port between NUM_PORTS requesters, with a per-transaction timeout.
// Ports:
//   clk, reset       : rising-edge clock, asynchronous active-low reset
//   portReq/Wr       : per-port request (held until ready) and write enable
//   portAddr/WData   : flattened per-port address and write data
//   portReady        : one-hot, one-cycle completion pulse
//   portErr          : with portReady, 1 = transaction timed out
//   portRData        : read data of the last normal completion
//   portGnt          : index of the port owning the current/last transaction
//   memAddr/Wr/DataIn: latched request towards memory
//   memReq           : one-cycle memory request pulse
//   memBusyOut       : memory busy, low = access finished
//   memDataOut       : read data from memory
// ---------------------------------------------------------------------------
module rr_mem_arbiter
   import rr_arb_pkg::*;
#(
   parameter int  NUM_PORTS = 4,
   parameter int  ADDR_W    = 32,
   parameter int  DATA_W    = 32,
   parameter int  TIMEOUT   = 256,
   localparam int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS-1:0]        portReq,
   input  logic [NUM_PORTS-1:0]        portWr,
   input  logic [NUM_PORTS*ADDR_W-1:0] portAddr,
   input  logic [NUM_PORTS*DATA_W-1:0] portWData,
   output logic [NUM_PORTS-1:0]        portReady,
   output logic                        portErr,
   output logic [DATA_W-1:0]           portRData,
   output logic [IDX_W-1:0]            portGnt,
   output logic [ADDR_W-1:0]           memAddr,
   output logic                        memWr,
   output logic                        memReq,
   output logic [DATA_W-1:0]           memDataIn,
   input  logic                        memBusyOut,
   input  logic [DATA_W-1:0]           memDataOut
);

   localparam int TIMER_W = timerWidth(TIMEOUT);

   arbState_t            r_state;
   arbState_t            w_stateNext;
   logic [IDX_W-1:0]     r_ptr;
   logic [TIMER_W-1:0]   r_timer;
   logic [NUM_PORTS-1:0] r_ready;
   logic                 r_err;
   logic [DATA_W-1:0]    r_rData;
   logic [IDX_W-1:0]     r_gnt;
   logic [ADDR_W-1:0]    r_memAddr;
   logic                 r_memWr;
   logic                 r_memReq;
   logic [DATA_W-1:0]    r_memDataIn;

   logic                 w_any;
   logic [IDX_W-1:0]     w_winner;
   logic [ADDR_W-1:0]    w_winAddr;
   logic [DATA_W-1:0]    w_winData;
   logic                 w_winWr;
   logic [NUM_PORTS-1:0] w_gntOneHot;
   logic                 w_timeout;

   arb_rr_pick #(
      .NUM_PORTS (NUM_PORTS)
   ) u_pick (
      .i_req    (portReq),
      .i_ptr    (r_ptr),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   // Pull the winner's address, data and write flag out of the flattened
   // request buses; only consumed when a grant is taken in IDLE.
   always_comb begin
      w_winAddr = '0;
      w_winData = '0;
      w_winWr   = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_winner == IDX_W'(i)) begin
            w_winAddr = portAddr[i*ADDR_W +: ADDR_W];
            w_winData = portWData[i*DATA_W +: DATA_W];
            w_winWr   = portWr[i];
         end
      end
   end

   // One-hot ready pattern for the port currently holding the grant.
   always_comb begin
      w_gntOneHot        = '0;
      w_gntOneHot[r_gnt] = 1'b1;
   end

   assign w_timeout = (r_timer == TIMER_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic. In WAIT a falling busy and an expiring timer both
   // move to DONE; which of the two it was is sorted out in the datapath.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_stateNext = ARB_REQUEST;
            end
         end
         ARB_REQUEST: begin
            w_stateNext = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (!memBusyOut || w_timeout) begin
               w_stateNext = ARB_DONE;
            end
         end
         ARB_DONE: begin
            w_stateNext = ARB_IDLE;
         end
         default: begin
            w_stateNext = ARB_IDLE;
         end
      endcase
   end

   // Datapath. Requests are only looked at in IDLE, so anything a requester
   // does after its grant has no effect until the next round. Busy low wins
   // over the timeout when both land in the same cycle; a timed-out access
   // leaves the last good read data in place. The pointer moves past the
   // served port only once the transaction is fully done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_timer     <= '0;
         r_ready     <= '0;
         r_err       <= 1'b0;
         r_rData     <= '0;
         r_gnt       <= '0;
         r_memAddr   <= '0;
         r_memWr     <= 1'b0;
         r_memReq    <= 1'b0;
         r_memDataIn <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_memAddr   <= w_winAddr;
                  r_memWr     <= w_winWr;
                  r_memDataIn <= w_winData;
                  r_gnt       <= w_winner;
                  r_memReq    <= 1'b1;
               end
            end
            ARB_REQUEST: begin
               r_memReq <= 1'b0;
               r_timer  <= '0;
            end
            ARB_WAIT: begin
               if (!memBusyOut) begin
                  r_rData <= memDataOut;
                  r_ready <= w_gntOneHot;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_ready <= w_gntOneHot;
                  r_err   <= 1'b1;
               end else begin
                  r_timer <= r_timer + TIMER_W'(1);
               end
            end
            ARB_DONE: begin
               r_ready <= '0;
               r_err   <= 1'b0;
               r_ptr   <= (r_gnt == IDX_W'(NUM_PORTS - 1)) ? '0 : r_gnt + IDX_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign portReady = r_ready;
   assign portErr   = r_err;
   assign portRData = r_rData;
   assign portGnt   = r_gnt;
   assign memAddr   = r_memAddr;
   assign memWr     = r_memWr;
   assign memReq    = r_memReq;
   assign memDataIn = r_memDataIn;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mem_arbiter
// Self-checking bench for rr_mem_arbiter (4 ports, TIMEOUT=8). Expected
// transactions are queued in grant order as stimulus is driven; a memory
// model answers each request with a programmed busy time, and completions
// are popped and compared as they appear.
// ---------------------------------------------------------------------------
module tb_rr_mem_arbiter;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [NP-1:0]  portReq;
   logic [NP-1:0]  portWr;
   logic [NP*AW-1:0] portAddr;
   logic [NP*DW-1:0] portWData;
   logic [NP-1:0]  portReady;
   logic           portErr;
   logic [DW-1:0]  portRData;
   logic [IW-1:0]  portGnt;
   logic [AW-1:0]  memAddr;
   logic           memWr;
   logic           memReq;
   logic [DW-1:0]  memDataIn;
   logic           memBusyOut;
   logic [DW-1:0]  memDataOut;

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          busy;
      logic        err;
      logic        gapCheck;
      logic        startCheck;
      int          stimCycle;
   } expT;

   expT         expQ[$];
   int          total = 0;
   int          bad = 0;
   int          cycle = 0;
   int          reqCycle = 0;
   int          lastReadyCycle = 0;
   int          busyCnt = 0;
   logic        busyStuck = 1'b0;
   logic        prevMemReq = 1'b0;
   logic [31:0] lastRData = 32'h0;
   int          remaining[NP];

   rr_mem_arbiter #(
      .NUM_PORTS (NP),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .TIMEOUT   (TO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .portReq    (portReq),
      .portWr     (portWr),
      .portAddr   (portAddr),
      .portWData  (portWData),
      .portReady  (portReady),
      .portErr    (portErr),
      .portRData  (portRData),
      .portGnt    (portGnt),
      .memAddr    (memAddr),
      .memWr      (memWr),
      .memReq     (memReq),
      .memDataIn  (memDataIn),
      .memBusyOut (memBusyOut),
      .memDataOut (memDataOut)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Contents of the memory model: every address reads back a distinct value.
   function automatic logic [31:0] memValue(input logic [31:0] a);
      return a ^ 32'hDEADBFEF;
   endfunction

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   // Queues one transaction for a port and raises its request.
   task automatic applyStimulus(input int port, input logic [31:0] addr, input logic wr,
                                input logic [31:0] wdata, input int busy, input logic err,
                                input logic gap, input logic start);
      expT e;
      e.idx = port; e.addr = addr; e.wr = wr; e.wdata = wdata; e.busy = busy;
      e.err = err; e.gapCheck = gap; e.startCheck = start; e.stimCycle = cycle;
      expQ.push_back(e);
      portAddr[port*AW +: AW] = addr;
      portWData[port*DW +: DW] = wdata;
      portWr[port] = wr;
      remaining[port]++;
      portReq[port] = 1'b1;
   endtask

   // Advances one cycle and, at the falling edge, checks the request side,
   // runs the memory model, checks completions and updates the requesters.
   task automatic stepCycle();
      expT e;
      logic [31:0] expRData;
      @(negedge clk);
      cycle++;
      if (memReq === 1'b1) begin
         checkOutput("memReqPulse", 64'(prevMemReq), 64'd0);
         if (expQ.size() == 0) begin
            checkOutput("unexpectedReq", 64'(memReq), 64'd0);
         end else begin
            e = expQ[0];
            checkOutput("reqAddr", 64'(memAddr), 64'(e.addr));
            checkOutput("reqWr", 64'(memWr), 64'(e.wr));
            checkOutput("reqWData", 64'(memDataIn), 64'(e.wdata));
            checkOutput("reqGnt", 64'(portGnt), 64'(e.idx));
            if (e.startCheck) begin
               checkOutput("reqLatency", 64'(cycle - e.stimCycle), 64'd1);
            end
            busyStuck = (e.busy < 0);
            busyCnt = busyStuck ? 0 : e.busy + 1;
         end
         reqCycle = cycle;
         memDataOut = memValue(memAddr);
         memBusyOut = 1'b1;
      end else if (busyStuck) begin
         memBusyOut = 1'b1;
      end else if (busyCnt > 0) begin
         busyCnt--;
         memBusyOut = (busyCnt != 0);
      end
      prevMemReq = memReq;
      if (portReady !== '0) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedReady", 64'(portReady), 64'd0);
         end else begin
            e = expQ.pop_front();
            expRData = e.err ? lastRData : memValue(e.addr);
            lastRData = expRData;
            checkOutput("ready", 64'(portReady), 64'(1) << e.idx);
            checkOutput("err", 64'(portErr), 64'(e.err));
            checkOutput("rdata", 64'(portRData), 64'(expRData));
            checkOutput("gnt", 64'(portGnt), 64'(e.idx));
            checkOutput("holdAddr", 64'(memAddr), 64'(e.addr));
            checkOutput("holdWr", 64'(memWr), 64'(e.wr));
            checkOutput("holdWData", 64'(memDataIn), 64'(e.wdata));
            checkOutput("latency", 64'(cycle - reqCycle), e.err ? 64'(TO + 1) : 64'(e.busy + 2));
            if (e.gapCheck) begin
               checkOutput("readyGap", 64'(cycle - lastReadyCycle), 64'd4);
            end
         end
         lastReadyCycle = cycle;
         for (int i = 0; i < NP; i++) begin
            if (portReady[i]) begin
               if (remaining[i] > 0) remaining[i]--;
               portReq[i] = (remaining[i] != 0);
            end
         end
      end
   endtask

   // Runs until every queued transaction has completed, within a budget,
   // then lets the arbiter settle back into IDLE.
   task automatic waitDrain(input int maxCycles);
      for (int n = 0; n < maxCycles && expQ.size() != 0; n++) begin
         stepCycle();
      end
      if (expQ.size() != 0) begin
         checkOutput("drainTimeout", 64'(expQ.size()), 64'd0);
         expQ.delete();
      end
      stepCycle();
   endtask

   // All outputs must read zero while reset holds them.
   task automatic checkResetState();
      checkOutput("rstReady", 64'(portReady), 64'd0);
      checkOutput("rstErr", 64'(portErr), 64'd0);
      checkOutput("rstRData", 64'(portRData), 64'd0);
      checkOutput("rstGnt", 64'(portGnt), 64'd0);
      checkOutput("rstMemReq", 64'(memReq), 64'd0);
      checkOutput("rstMemWr", 64'(memWr), 64'd0);
      checkOutput("rstMemAddr", 64'(memAddr), 64'd0);
      checkOutput("rstMemDataIn", 64'(memDataIn), 64'd0);
   endtask

   // Clears all bench-side state that mirrors a transaction in flight.
   task automatic clearModel();
      expQ.delete();
      busyStuck = 1'b0;
      busyCnt = 0;
      memBusyOut = 1'b0;
      prevMemReq = 1'b0;
      lastRData = 32'h0;
      portReq = '0;
      for (int i = 0; i < NP; i++) remaining[i] = 0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      clearModel();
      stepCycle();
      stepCycle();
      reset = 1'b1;
      stepCycle();
   endtask

   // Main sequence of directed scenarios.
   initial begin
      reset = 1'b0;
      portReq = '0;
      portWr = '0;
      portAddr = '0;
      portWData = '0;
      memBusyOut = 1'b0;
      memDataOut = '0;
      for (int i = 0; i < NP; i++) remaining[i] = 0;
      stepCycle();
      stepCycle();
      checkResetState();
      reset = 1'b1;
      stepCycle();

      // Single read from port 0, memory answers in the first WAIT cycle.
      applyStimulus(0, 32'h100, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
      waitDrain(50);
      checkOutput("readData", 64'(portRData), 64'hDEADBEEF);

      // Everyone requesting continuously from a fresh pointer.
      doReset();
      applyStimulus(0, 32'h1000, 1'b0, 32'hA0, 0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 32'h1010, 1'b1, 32'hB1, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(2, 32'h1020, 1'b0, 32'hC2, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(3, 32'h1030, 1'b1, 32'hD3, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 32'h1000, 1'b0, 32'hA0, 0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1, 32'h1010, 1'b1, 32'hB1, 0, 1'b0, 1'b1, 1'b0);
      waitDrain(100);

      // Port 2 write with a slow memory; its inputs change after the grant.
      applyStimulus(2, 32'h40, 1'b1, 32'h12345678, 5, 1'b0, 1'b0, 1'b1);
      stepCycle();
      stepCycle();
      portAddr[2*AW +: AW] = 32'hFFFF0000;
      portWData[2*DW +: DW] = 32'h0;
      portWr[2] = 1'b0;
      waitDrain(50);

      // Pointer now at 3: port 3 goes before port 1, port 2 stays idle.
      applyStimulus(3, 32'h3000, 1'b0, 32'h33, 1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 32'h1100, 1'b0, 32'h11, 2, 1'b0, 1'b0, 1'b0);
      waitDrain(50);

      // Hung memory on port 2 times out; port 0 then completes with busy
      // falling exactly on the last timer cycle.
      applyStimulus(2, 32'h2200, 1'b0, 32'h22, -1, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 32'h0500, 1'b1, 32'h55AA, TO - 1, 1'b0, 1'b0, 1'b0);
      waitDrain(80);

      // Reset in the middle of a WAIT abandons the transaction.
      applyStimulus(2, 32'h2300, 1'b0, 32'h23, -1, 1'b1, 1'b0, 1'b1);
      stepCycle();
      stepCycle();
      stepCycle();
      stepCycle();
      #2;
      reset = 1'b0;
      #1;
      checkResetState();
      clearModel();
      stepCycle();
      stepCycle();
      reset = 1'b1;
      applyStimulus(1, 32'h1200, 1'b0, 32'h77, 0, 1'b0, 1'b0, 1'b1);
      waitDrain(50);

      stepCycle();
      stepCycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_mem_arbiter.md
Name: rr_mem_arbiter

Overview:
- Work-conserving round-robin arbiter that shares the single memory port between NUM_PORTS requesters, e.g. I-fetch, D load/store, DMA and debug.
- Replaces fixed time slotting: idle ports cost no cycles.
- Drives the same pulse-request / busy-wait memory handshake as the core's existing memory interface.
- Adds a per-transaction timeout so a hung memory cannot deadlock the core.

Parameters:
NUM_PORTS, 4, number of requesters (2..8, need not be a power of 2)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 256, max WAIT cycles before forced completion with error (>=2)
IDX_W, $clog2(NUM_PORTS), grant index width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
portReq  in  NUM_PORTS  per-port request, held until that port's ready
portWr  in  NUM_PORTS  per-port write enable
portAddr  in  NUM_PORTS*ADDR_W  flattened addresses, port i at [i*ADDR_W +: ADDR_W]
portWData  in  NUM_PORTS*DATA_W  flattened write data
portReady  out  NUM_PORTS  one-cycle completion pulse, one-hot
portErr  out  1  valid with portReady, 1 = transaction timed out
portRData  out  DATA_W  read data, valid with portReady, held until next completion
portGnt  out  IDX_W  index of port owning the current/last transaction
memAddr  out  ADDR_W  memory address
memWr  out  1  memory write
memReq  out  1  one-cycle request pulse
memDataIn  out  DATA_W  write data to memory
memBusyOut  in  1  memory busy
memDataOut  in  DATA_W  read data from memory

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, portReady=0, portErr=0, portRData=0, portGnt=0, memReq=0, memWr=0, memAddr=0, memDataIn=0, timer=0.
- States: IDLE, REQUEST, WAIT, DONE.
- IDLE:
  - portReq sampled only here.
  - If any bit is set, the winner is the first requesting index scanning ptr, ptr+1, ... with wrap from NUM_PORTS-1 to 0.
  - Latch memAddr, memWr, memDataIn from the winner; portGnt<=winner; memReq<=1; -> REQUEST.
  - No request: stay in IDLE, ptr unchanged.
- REQUEST: memReq<=0; timer<=0; -> WAIT. memReq is high for exactly one cycle.
- WAIT:
  - memBusyOut==0: portRData<=memDataOut; portReady[portGnt]<=1; portErr<=0; -> DONE.
  - Else, if timer==TIMEOUT-1: portReady[portGnt]<=1; portErr<=1; portRData unchanged; -> DONE.
  - Else timer<=timer+1.
  - busy low is checked before timeout; if both occur in the same cycle, the transaction completes normally.
- DONE: portReady<=0; portErr<=0; ptr<=(portGnt==NUM_PORTS-1)?0:portGnt+1; -> IDLE.
- Latency: req sampled at edge t gives memReq high in cycle t+1. Busy low in the first WAIT cycle gives portReady high in cycle t+3. Minimum 4 cycles per transaction.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 other transactions.
- memAddr, memWr and memDataIn hold their latched values until the next grant. Requester inputs changing after the grant have no effect.
- A request deasserted before grant is simply not served. A request still high in the cycle after its portReady is treated as a new transaction.
- portWr=1 transactions still update portRData from memDataOut. Requesters ignore portRData on writes.
- Reset mid-transaction: the transaction is abandoned with no ready pulse, and memReq drops immediately.

Decomposition:
- Shared package rr_arb_pkg: state encodings ARB_IDLE=0, ARB_REQUEST=1, ARB_WAIT=2, ARB_DONE=3 (2-bit), and the timer width function.
- One combinational sub-module, arb_rr_pick:
  - Inputs: req vector, ptr.
  - Outputs: any, winner index.
  - Implementation: rotate, priority-encode, unrotate, reduce modulo NUM_PORTS.

Test Plan:
- Single port 0 read, portAddr0=0x100, busy low on the first WAIT cycle, memDataOut=0xDEADBEEF -> memReq pulse at t+1 with memAddr=0x100, memWr=0; portReady=4'b0001 at t+3; portRData=0xDEADBEEF; portErr=0.
- All 4 ports request continuously, busy always low -> grant order 0,1,2,3,0,1; one portReady pulse every 4 cycles.
- Ports 1 and 3 request after a port-2 transaction (ptr=3) -> port 3 served first, then port 1; port 2 is not served.
- Port 2 write, addr 0x40, data 0x12345678, busy high for 5 WAIT cycles -> memWr=1, memDataIn=0x12345678 held throughout; portReady[2] one cycle after busy falls.
- TIMEOUT=8, busy stuck high -> portReady[gnt]=1 and portErr=1 after 8 WAIT cycles; the next requester is served afterwards.
- Reset asserted in WAIT -> all outputs 0 asynchronously; after release with port 1 requesting, port 1 is granted with ptr starting from 0.
